// File: rtl/mux8_pkg.sv
// Shared types and sizing for the registered 8:1 selector.
// No logic; constants only.
// Imported by mux8_core and mux8.
package mux8_pkg;
   localparam int NUM_INPUTS = 8;
   localparam int SEL_W      = 3;

   typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux8_core.sv
// Purpose: combinational 8:1 word select, data<sel> -> sel_dat.
// Latency: zero (pure combinational).
// Backpressure: none; no state, no flow control.
module mux8_core
   import mux8_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [WIDTH-1:0] data3,
   input  logic [WIDTH-1:0] data4,
   input  logic [WIDTH-1:0] data5,
   input  logic [WIDTH-1:0] data6,
   input  logic [WIDTH-1:0] data7,
   input  sel_t             sel,
   output logic [WIDTH-1:0] sel_dat
);

   // Every code 0..7 is decoded explicitly; the leading assignment only keeps
   // the block latch-free and is always overridden, so unselected inputs never
   // leak into the result.
   always_comb begin
      sel_dat = data0;
      case (sel)
         3'd0: sel_dat = data0;
         3'd1: sel_dat = data1;
         3'd2: sel_dat = data2;
         3'd3: sel_dat = data3;
         3'd4: sel_dat = data4;
         3'd5: sel_dat = data5;
         3'd6: sel_dat = data6;
         3'd7: sel_dat = data7;
      endcase
   end

endmodule

// File: rtl/mux8.sv
// Purpose: registered 8:1 selector; captures data<sel> and sel when in_valid.
// Latency: 1 clock from capturing edge to out/out_sel/out_valid.
// Backpressure: none; accepts a word every cycle, out_valid is a 1-cycle pulse per capture.
module mux8
   import mux8_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [WIDTH-1:0] data3,
   input  logic [WIDTH-1:0] data4,
   input  logic [WIDTH-1:0] data5,
   input  logic [WIDTH-1:0] data6,
   input  logic [WIDTH-1:0] data7,
   input  sel_t             sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output sel_t             out_sel,
   output logic             out_valid
);

   logic [WIDTH-1:0] sel_dat;
   logic [WIDTH-1:0] out_d, out_q;
   sel_t             out_sel_d, out_sel_q;
   logic             out_valid_d, out_valid_q;

   mux8_core #(.WIDTH(WIDTH)) u_core (
      .data0   (data0),
      .data1   (data1),
      .data2   (data2),
      .data3   (data3),
      .data4   (data4),
      .data5   (data5),
      .data6   (data6),
      .data7   (data7),
      .sel     (sel),
      .sel_dat (sel_dat)
   );

   // Next state: load on in_valid, otherwise hold the word and drop valid.
   always_comb begin
      out_d       = out_q;
      out_sel_d   = out_sel_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_d       = sel_dat;
         out_sel_d   = sel;
         out_valid_d = 1'b1;
      end
   end

   // Output registers; synchronous reset wins over a same-edge capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8.sv
// Bench for mux8: directed vector table, mid-cycle glitch sequence,
// then randomized traffic against a behavioural reference model.
module tb_mux8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din [8];
   logic [2:0] sel;
   logic       in_valid;
   logic [7:0] out;
   logic [2:0] out_sel;
   logic       out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux8 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data0     (din[0]),
      .data1     (din[1]),
      .data2     (din[2]),
      .data3     (din[3]),
      .data4     (din[4]),
      .data5     (din[5]),
      .data6     (din[6]),
      .data7     (din[7]),
      .sel       (sel),
      .in_valid  (in_valid),
      .out       (out),
      .out_sel   (out_sel),
      .out_valid (out_valid)
   );

   typedef struct {
      logic            rst_n;
      logic            iv;
      logic [2:0]      sel;
      logic [7:0][7:0] d;
      logic [7:0]      e_out;
      logic [2:0]      e_sel;
      logic            e_vld;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic iv, input logic [2:0] s,
                      input logic [7:0][7:0] d, input logic [7:0] eo,
                      input logic [2:0] es, input logic ev);
      vec_t v;
      v.rst_n = r; v.iv = iv; v.sel = s; v.d = d;
      v.e_out = eo; v.e_sel = es; v.e_vld = ev;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic iv, input logic [2:0] s,
                        input logic [7:0][7:0] d);
      rst_n = r; in_valid = iv; sel = s;
      for (int k = 0; k < 8; k++) din[k] = d[k];
   endtask

   // Reference model state: what the outputs should hold after the next edge.
   logic [7:0] m_out;
   logic [2:0] m_sel;
   logic       m_vld;

   initial begin
      logic [7:0][7:0] dv;
      logic [7:0]      word [8];

      // Reset with a live capture request: nothing may get through.
      dv = '0; dv[3] = 8'hA5;
      add(1'b0, 1'b1, 3'd3, dv, 8'h00, 3'd0, 1'b0);
      add(1'b0, 1'b1, 3'd3, dv, 8'h00, 3'd0, 1'b0);
      // Full sweep of every sel code, back-to-back.
      for (int k = 0; k < 8; k++) dv[k] = 8'h10 + 8'(k);
      for (int k = 0; k < 8; k++)
         add(1'b1, 1'b1, 3'(k), dv, 8'h10 + 8'(k), 3'(k), 1'b1);
      // Capture then hold while inputs move.
      dv = '0; dv[5] = 8'h3C;
      add(1'b1, 1'b1, 3'd5, dv, 8'h3C, 3'd5, 1'b1);
      dv[5] = 8'hFF;
      for (int k = 0; k < 3; k++)
         add(1'b1, 1'b0, 3'(k), dv, 8'h3C, 3'd5, 1'b0);
      // Reset beats a simultaneous capture; next edge captures normally.
      dv = '0; dv[7] = 8'h81;
      add(1'b0, 1'b1, 3'd7, dv, 8'h00, 3'd0, 1'b0);
      add(1'b1, 1'b1, 3'd7, dv, 8'h81, 3'd7, 1'b1);

      drive(1'b0, 1'b0, 3'd0, '0);
      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].iv, vecs[i].sel, vecs[i].d);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_out", i),     32'(out),       32'(vecs[i].e_out));
         chk($sformatf("vec%0d_sel", i),     32'(out_sel),   32'(vecs[i].e_sel));
         chk($sformatf("vec%0d_vld", i),     32'(out_valid), 32'(vecs[i].e_vld));
      end

      // Glitch: inputs moving between edges must not reach the outputs.
      in_valid = 1'b1; sel = 3'd1; din[1] = 8'hAA;
      #3;
      chk("glitch_mid_out", 32'(out), 32'h81);
      sel = 3'd6; din[6] = 8'h55;
      @(posedge clk); #1;
      chk("glitch_cap_out", 32'(out),       32'h55);
      chk("glitch_cap_sel", 32'(out_sel),   32'd6);
      chk("glitch_cap_vld", 32'(out_valid), 32'd1);
      sel = 3'd0; din[0] = 8'h00; din[6] = 8'h00;
      #3;
      chk("glitch_hold_out", 32'(out),     32'h55);
      chk("glitch_hold_sel", 32'(out_sel), 32'd6);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("glitch_idle_out", 32'(out),       32'h55);
      chk("glitch_idle_vld", 32'(out_valid), 32'd0);

      // Unselected inputs unknown, selected one clean.
      for (int k = 0; k < 8; k++) din[k] = 8'hxx;
      din[2] = 8'h5A; sel = 3'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("xsel_out", 32'(out),     32'h5A);
      chk("xsel_sel", 32'(out_sel), 32'd2);

      // Randomized traffic against the model.
      m_out = out; m_sel = out_sel; m_vld = out_valid;
      for (int c = 0; c < 10000; c++) begin
         rst_n    = ($urandom_range(0, 63) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         sel      = 3'($urandom_range(0, 7));
         for (int k = 0; k < 8; k++) begin
            word[k] = 8'($urandom);
            din[k]  = word[k];
         end
         if (!rst_n) begin
            m_out = 8'h00; m_sel = 3'd0; m_vld = 1'b0;
         end else if (in_valid) begin
            m_out = word[sel]; m_sel = sel; m_vld = 1'b1;
         end else begin
            m_vld = 1'b0;
         end
         @(posedge clk); #1;
         chk("rand_vld", 32'(out_valid), 32'(m_vld));
         chk("rand_sel", 32'(out_sel),   32'(m_sel));
         chk("rand_out", 32'(out),       32'(m_out));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux8.md
MUX8 -- requirements
Module: mux8

Interface
REQ-001 Parameter WIDTH, default 8, data width of every data input and of out.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Ports data0..data7  input  WIDTH each  candidate data words, index 0..7.
REQ-005 Port sel  input  3  selects data<sel> as the source word.
REQ-006 Port in_valid  input  1  qualifies data0..data7 and sel for capture this cycle.
REQ-007 Port out  output  WIDTH  registered selected word.
REQ-008 Port out_valid  output  1  high for exactly the cycle(s) in which out carries a freshly captured word.
REQ-009 Port out_sel  output  3  registered copy of the sel value that produced out.

Function
REQ-010 On a rising clk edge with rst_n=1 and in_valid=1, out SHALL load data<sel>, out_sel SHALL load sel, and out_valid SHALL be 1 in the following cycle.
REQ-011 Latency SHALL be exactly 1 clock from the capturing edge to out/out_valid; no combinational path from any input to any output.
REQ-012 On a rising clk edge with rst_n=1 and in_valid=0, out and out_sel SHALL hold their previous values and out_valid SHALL be 0.
REQ-013 Back-to-back in_valid=1 cycles SHALL each produce one result; out_valid stays high continuously and out updates every cycle (full throughput, no stall).
REQ-014 All 8 sel codes 0..7 SHALL be legal; sel=k maps to data<k> with no gaps, no default-to-zero case reachable.
REQ-015 Selection SHALL be bit-exact; no sign extension, truncation or inversion of the selected word at any WIDTH.
REQ-016 An X-free sel with X on unselected data inputs SHALL produce an X-free out.
REQ-017 Changes to data or sel between clock edges SHALL have no effect on outputs until the next capturing edge.

Reset
REQ-018 While rst_n=0 at a rising clk edge, out SHALL become 0, out_sel 0 and out_valid 0, regardless of in_valid.
REQ-019 Reset SHALL take priority over a simultaneous in_valid=1; that input is dropped, not captured.
REQ-020 Reset asserted mid-stream SHALL clear outputs at that edge; first edge with rst_n=1 and in_valid=1 SHALL capture normally (no extra idle cycle).
REQ-021 Outputs before the first clock edge are undefined; no asynchronous reset path.

Structure
REQ-022 Shared package mux8_pkg SHALL hold localparams NUM_INPUTS=8 and SEL_W=3 plus a sel_t typedef (logic [SEL_W-1:0]).
REQ-023 Combinational select SHALL live in one sub-module mux8_core (data0..data7, sel -> selected word); mux8 wraps it with the output registers.

Verification
REQ-024 Reset: rst_n=0 for 2 cycles with in_valid=1, sel=3, data3=8'hA5 -> out=8'h00, out_sel=0, out_valid=0 throughout.
REQ-025 Sweep: data<k>=8'h10+k, in_valid=1, sel=0..7 on consecutive cycles -> out=8'h10..8'h17 one cycle later each, out_valid continuously 1, out_sel tracking 0..7.
REQ-026 Hold: capture sel=5, data5=8'h3C, then in_valid=0 and data5=8'hFF for 3 cycles -> out stays 8'h3C, out_sel=5, out_valid=0.
REQ-027 Reset priority: rst_n=0 and in_valid=1, sel=7, data7=8'h81 on same edge -> out=8'h00, out_valid=0; next edge with rst_n=1 -> out=8'h81, out_valid=1.
REQ-028 Random: 10,000 cycles of $random data0..data7, sel, in_valid -> out equals scoreboard model data<sel> delayed 1 cycle whenever out_valid=1.
REQ-029 Glitch: change sel and data mid-cycle with in_valid=1 -> outputs reflect only values present at the rising edge.
